mm_cmd_sequencer: RTL and testbench
===================================

// Module: mm_cmd_sequencer
// PURPOSE
//  Host-side command front-end directly upstream of the mm accelerator controller.
//  Queues matmul commands (m, k, n, base addresses, tag) in a small FIFO. Launches
//  them one at a time through the controller's level start/valid handshake and
//  holds the parameters stable for the whole job. Returns one completion record
//  per command (tag, error flag, cycle count) on a valid/ready port.
// PARAMETERS
//  ADDR_WIDTH  16  width of dimensions and buffer addresses (matches `ADDR_WIDTH)
//  ID_WIDTH    4   command tag width
//  DEPTH       4   command FIFO entries, power of two, >= 2
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_i          in   1           asynchronous active-high reset
//  cmd_valid_i    in   1           command valid
//  cmd_ready_o    out  1           command ready (FIFO not full)
//  cmd_m_i/k_i/n_i in  ADDR_WIDTH  matrix dimensions
//  cmd_base_a_i   in   ADDR_WIDTH  base address, buffer A
//  cmd_base_b_i   in   ADDR_WIDTH  base address, buffer B
//  cmd_base_p_i   in   ADDR_WIDTH  base address, buffer P
//  cmd_id_i       in   ID_WIDTH    command tag
//  start_o        out  1           to controller start_i
//  m_o/k_o/n_o    out  ADDR_WIDTH  to controller m_i/k_i/n_i
//  base_addra_o   out  ADDR_WIDTH  to controller base_addra_i (b/p same pattern)
//  base_addrb_o   out  ADDR_WIDTH
//  base_addrp_o   out  ADDR_WIDTH
//  ctrl_valid_i   in   1           from controller valid_o
//  done_valid_o   out  1           completion record valid
//  done_ready_i   in   1           completion record accepted
//  done_id_o      out  ID_WIDTH    tag of completed command
//  done_err_o     out  1           1 = command rejected (a dimension was zero)
//  done_cycles_o  out  32          cycles with start_o high before ctrl_valid_i rose
//  busy_o         out  1           state != IDLE or FIFO non-empty
// BEHAVIOUR
//  - Reset: FIFO empty; state IDLE; every output 0 except cmd_ready_o=1.
//    Applies asynchronously, mid-job included; start_o drops immediately.
//  - FIFO: push on cmd_valid_i & cmd_ready_o; cmd_ready_o = (count != DEPTH), registered count.
//    Push and pop in the same cycle leaves count unchanged. Pointers wrap mod DEPTH.
//  - FSM, registered, states IDLE/LAUNCH/RELEASE/REPORT:
//    IDLE: FIFO non-empty -> pop the head into the active registers.
//      Any of m,k,n == 0 -> REPORT with err=1 (start_o never asserts).
//      Otherwise -> LAUNCH with the cycle counter cleared.
//    LAUNCH: start_o=1; the counter increments each cycle.
//      ctrl_valid_i=1 -> RELEASE; the counter freezes and is latched into done_cycles_o.
//    RELEASE: start_o=0; wait ctrl_valid_i=0 -> REPORT, err=0.
//    REPORT: done_valid_o=1. id/err/cycles stay stable while done_ready_i=0.
//      done_ready_i=1 -> IDLE.
//  - start_o = (state==LAUNCH), decoded from the state register (glitch-free).
//    First high cycle is the cycle after the pop edge.
//    Command accepted into an empty FIFO at edge E0: pop at E1, start_o high after E1.
//  - m_o..base_addrp_o come only from the active registers.
//    They are constant from the pop edge through REPORT exit.
//    They are 0 after reset until the first pop.
//  - A new command is launched only after the previous completion is accepted.
//    Completions are strictly in order.
//  - done_cycles_o saturates at 32'hFFFF_FFFF.
//  - ctrl_valid_i high while IDLE or REPORT is ignored (no state change).
// TESTING
//  1. Push m=8,k=8,n=8,id=3 and model the controller (valid_o after 20 start cycles).
//     -> start_o high 20 cycles, drops the cycle after valid.
//     -> done_valid_o with id=3, err=0, cycles=20.
//  2. Push 5 commands back-to-back with the controller stalled.
//     -> cmd_ready_o low after the 4th accept; 5th accepted once the first pop occurs.
//     -> Tags completed in order 0..4.
//  3. Command with k=0, id=7 -> no start_o pulse.
//     -> done_valid_o next-next cycle with id=7, err=1.
//  4. Hold done_ready_i=0 for 10 cycles in REPORT with a second command queued.
//     -> Outputs stable; start_o stays 0 until the accept.
//  5. Assert rst_i mid-LAUNCH -> start_o=0 immediately; FIFO empty; cmd_ready_o=1.
//     -> No done_valid_o after release.
//  6. Keep ctrl_valid_i high for 3 cycles after start_o falls.
//     -> done_valid_o rises only after ctrl_valid_i returns to 0; cycles unchanged.

Source files
------------

// File: rtl/mm_cmd_sequencer.sv
// Command front-end for the mm accelerator controller: queues matmul commands, launches them
// one at a time over a level start/valid handshake and returns one in-order completion record each.
module mm_cmd_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_m_i,
    input  logic [ADDR_WIDTH-1:0] cmd_k_i,
    input  logic [ADDR_WIDTH-1:0] cmd_n_i,
    input  logic [ADDR_WIDTH-1:0] cmd_base_a_i,
    input  logic [ADDR_WIDTH-1:0] cmd_base_b_i,
    input  logic [ADDR_WIDTH-1:0] cmd_base_p_i,
    input  logic [ID_WIDTH-1:0]   cmd_id_i,
    output logic                  start_o,
    output logic [ADDR_WIDTH-1:0] m_o,
    output logic [ADDR_WIDTH-1:0] k_o,
    output logic [ADDR_WIDTH-1:0] n_o,
    output logic [ADDR_WIDTH-1:0] base_addra_o,
    output logic [ADDR_WIDTH-1:0] base_addrb_o,
    output logic [ADDR_WIDTH-1:0] base_addrp_o,
    input  logic                  ctrl_valid_i,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic [ID_WIDTH-1:0]   done_id_o,
    output logic                  done_err_o,
    output logic [31:0]           done_cycles_o,
    output logic                  busy_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 6 * ADDR_WIDTH + ID_WIDTH;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LAUNCH  = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] REPORT  = 2'd3;

    logic [1:0]            state;
    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head;
    logic [ADDR_WIDTH-1:0] head_m;
    logic [ADDR_WIDTH-1:0] head_k;
    logic [ADDR_WIDTH-1:0] head_n;
    logic [ADDR_WIDTH-1:0] head_a;
    logic [ADDR_WIDTH-1:0] head_b;
    logic [ADDR_WIDTH-1:0] head_p;
    logic [ID_WIDTH-1:0]   head_id;
    logic                  head_zero;
    logic [ID_WIDTH-1:0]   act_id;
    logic [31:0]           cycle_cnt;

    assign cmd_ready_o = (count != FULL_COUNT);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state == IDLE) && (count != '0);

    assign wr_entry = {cmd_m_i, cmd_k_i, cmd_n_i, cmd_base_a_i, cmd_base_b_i, cmd_base_p_i, cmd_id_i};
    assign head     = fifo_mem[rd_ptr];
    assign {head_m, head_k, head_n, head_a, head_b, head_p, head_id} = head;
    assign head_zero = (head_m == '0) || (head_k == '0) || (head_n == '0);

    // Storage needs no reset: nothing reads an entry before it has been written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Active registers are loaded only at the pop edge, so the controller sees stable
    // parameters from launch until the completion record has been accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            m_o           <= '0;
            k_o           <= '0;
            n_o           <= '0;
            base_addra_o  <= '0;
            base_addrb_o  <= '0;
            base_addrp_o  <= '0;
            act_id        <= '0;
            cycle_cnt     <= '0;
            done_cycles_o <= '0;
            done_err_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        m_o           <= head_m;
                        k_o           <= head_k;
                        n_o           <= head_n;
                        base_addra_o  <= head_a;
                        base_addrb_o  <= head_b;
                        base_addrp_o  <= head_p;
                        act_id        <= head_id;
                        cycle_cnt     <= '0;
                        done_cycles_o <= '0;
                        done_err_o    <= head_zero;
                        state         <= head_zero ? REPORT : LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (ctrl_valid_i) begin
                        done_cycles_o <= cycle_cnt;
                        state         <= RELEASE;
                    end else if (cycle_cnt != 32'hFFFF_FFFF) begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                end
                RELEASE: begin
                    if (!ctrl_valid_i) begin
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    if (done_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_o      = (state == LAUNCH);
    assign done_valid_o = (state == REPORT);
    assign done_id_o    = act_id;
    assign busy_o       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_mm_cmd_sequencer.sv
// Directed bench for mm_cmd_sequencer: a table of commands with hand-computed completions,
// plus hand-written sequences for backpressure, completion stall, reset mid-job and reset state.
module tb_mm_cmd_sequencer;

    typedef struct {
        logic [15:0] m;
        logic [15:0] k;
        logic [15:0] n;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic [3:0]  id;
        int          lat;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_cycles;
    } cmd_vec_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready_o;
    logic [15:0] cmd_m, cmd_k, cmd_n, cmd_a, cmd_b, cmd_p;
    logic [3:0]  cmd_id;
    logic        start_o;
    logic [15:0] m_o, k_o, n_o, base_addra_o, base_addrb_o, base_addrp_o;
    logic        ctrl_valid;
    logic        done_valid_o;
    logic        done_ready;
    logic [3:0]  done_id_o;
    logic        done_err_o;
    logic [31:0] done_cycles_o;
    logic        busy_o;

    int tests_run;
    int tests_failed;

    cmd_vec_t vec [7];
    logic [31:0] exp_burst_cycles [5];

    mm_cmd_sequencer #(
        .ADDR_WIDTH(16),
        .ID_WIDTH  (4),
        .DEPTH     (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_m_i      (cmd_m),
        .cmd_k_i      (cmd_k),
        .cmd_n_i      (cmd_n),
        .cmd_base_a_i (cmd_a),
        .cmd_base_b_i (cmd_b),
        .cmd_base_p_i (cmd_p),
        .cmd_id_i     (cmd_id),
        .start_o      (start_o),
        .m_o          (m_o),
        .k_o          (k_o),
        .n_o          (n_o),
        .base_addra_o (base_addra_o),
        .base_addrb_o (base_addrb_o),
        .base_addrp_o (base_addrp_o),
        .ctrl_valid_i (ctrl_valid),
        .done_valid_o (done_valid_o),
        .done_ready_i (done_ready),
        .done_id_o    (done_id_o),
        .done_err_o   (done_err_o),
        .done_cycles_o(done_cycles_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one command at a negedge; it is taken by the following rising edge.
    task automatic applyStimulus(input cmd_vec_t v);
        cmd_m     = v.m;
        cmd_k     = v.k;
        cmd_n     = v.n;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_p     = v.p;
        cmd_id    = v.id;
        cmd_valid = 1'b1;
        checkOutput("cmd_ready_on_push", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Controller model: raises valid in the cycle after 'lat' start cycles, holds it
    // 'hold' extra cycles after start falls, then drops it.
    task automatic serveJob(input int lat, input int hold);
        int guard;
        int cnt;
        guard = 0;
        cnt   = 0;
        while (!start_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("start_seen", start_o, 1);
        while (cnt < lat && start_o) begin
            cnt++;
            @(negedge clk);
        end
        ctrl_valid = 1'b1;
        @(negedge clk);
        checkOutput("start_drop_after_valid", start_o, 0);
        for (int i = 0; i < hold; i++) begin
            checkOutput("no_done_while_valid_held", done_valid_o, 0);
            @(negedge clk);
        end
        ctrl_valid = 1'b0;
    endtask

    task automatic waitDone(input logic [3:0] id, input logic err, input logic [31:0] cycles);
        int guard;
        guard = 0;
        while (!done_valid_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("done_valid", done_valid_o, 1);
        checkOutput("done_id", done_id_o, id);
        checkOutput("done_err", done_err_o, err);
        checkOutput("done_cycles", done_cycles_o, cycles);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checkOutput("done_drop_after_accept", done_valid_o, 0);
    endtask

    initial begin
        cmd_vec_t v;
        logic     seen;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_m        = '0;
        cmd_k        = '0;
        cmd_n        = '0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_p        = '0;
        cmd_id       = '0;
        ctrl_valid   = 1'b0;
        done_ready   = 1'b0;

        //          m         k         n         a         b         p         id  lat hold err cycles
        vec[0] = '{16'd8,    16'd8,    16'd8,    16'h0100, 16'h0200, 16'h0300, 4'd3,  20, 0, 1'b0, 32'd20};
        vec[1] = '{16'd1,    16'd1,    16'd1,    16'h0010, 16'h0020, 16'h0030, 4'd1,  1,  0, 1'b0, 32'd1};
        vec[2] = '{16'd4,    16'd0,    16'd4,    16'h1111, 16'h2222, 16'h3333, 4'd7,  0,  0, 1'b1, 32'd0};
        vec[3] = '{16'd16,   16'd2,    16'd3,    16'h0A00, 16'h0B00, 16'h0C00, 4'd5,  0,  0, 1'b0, 32'd0};
        vec[4] = '{16'd0,    16'd5,    16'd5,    16'h0001, 16'h0002, 16'h0003, 4'd9,  0,  0, 1'b1, 32'd0};
        vec[5] = '{16'd3,    16'd3,    16'd0,    16'h00AA, 16'h00BB, 16'h00CC, 4'd15, 0,  0, 1'b1, 32'd0};
        vec[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFF0, 16'hFFF1, 16'hFFF2, 4'd10, 6,  3, 1'b0, 32'd6};
        exp_burst_cycles = '{32'd3, 32'd2, 32'd2, 32'd2, 32'd2};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_cmd_ready", cmd_ready_o, 1);
        checkOutput("reset_start", start_o, 0);
        checkOutput("reset_done_valid", done_valid_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_m", m_o, 0);
        checkOutput("reset_base_p", base_addrp_o, 0);
        checkOutput("reset_done_cycles", done_cycles_o, 0);

        // Table: push into an empty FIFO, check launch latency, serve, check completion.
        for (int i = 0; i < 7; i++) begin
            v = vec[i];
            applyStimulus(v);
            checkOutput("start_before_pop", start_o, 0);
            @(negedge clk);
            if (v.exp_err) begin
                checkOutput("err_no_start", start_o, 0);
                checkOutput("err_done_latency", done_valid_o, 1);
            end else begin
                checkOutput("start_latency", start_o, 1);
                serveJob(v.lat, v.hold);
            end
            checkOutput("param_m", m_o, v.m);
            checkOutput("param_k", k_o, v.k);
            checkOutput("param_n", n_o, v.n);
            checkOutput("param_a", base_addra_o, v.a);
            checkOutput("param_b", base_addrb_o, v.b);
            checkOutput("param_p", base_addrp_o, v.p);
            waitDone(v.id, v.exp_err, v.exp_cycles);
            checkOutput("idle_not_busy", busy_o, 0);
        end

        // Backpressure: a blocker job stalls in LAUNCH while five commands arrive.
        v = '{16'd2, 16'd2, 16'd2, 16'h0, 16'h0, 16'h0, 4'd12, 0, 0, 1'b0, 32'd0};
        applyStimulus(v);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            v = '{16'd2, 16'd2, 16'd2, 16'h10, 16'h20, 16'h30, 4'(i), 2, 0, 1'b0, 32'd2};
            applyStimulus(v);
        end
        cmd_id    = 4'd4;
        cmd_valid = 1'b1;
        checkOutput("full_after_4th", cmd_ready_o, 0);
        checkOutput("blocker_stalled", start_o, 1);
        serveJob(0, 0);
        waitDone(4'd12, 1'b0, 32'd4);
        checkOutput("still_full_before_pop", cmd_ready_o, 0);
        @(negedge clk);
        checkOutput("ready_after_first_pop", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("full_after_5th", cmd_ready_o, 0);
        for (int i = 0; i < 5; i++) begin
            serveJob(2, 0);
            waitDone(4'(i), 1'b0, exp_burst_cycles[i]);
        end

        // Completion stalled for 10 cycles with a second command queued behind it.
        v = '{16'd5, 16'd6, 16'd7, 16'h0040, 16'h0050, 16'h0060, 4'd2, 3, 0, 1'b0, 32'd3};
        applyStimulus(v);
        v = '{16'd9, 16'd9, 16'd9, 16'h0070, 16'h0080, 16'h0090, 4'd6, 1, 0, 1'b0, 32'd1};
        applyStimulus(v);
        serveJob(3, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_done_valid", done_valid_o, 1);
            checkOutput("stall_id", done_id_o, 4'd2);
            checkOutput("stall_cycles", done_cycles_o, 32'd3);
            checkOutput("stall_no_start", start_o, 0);
            checkOutput("stall_m", m_o, 16'd5);
        end
        waitDone(4'd2, 1'b0, 32'd3);
        serveJob(1, 0);
        checkOutput("second_cmd_m", m_o, 16'd9);
        waitDone(4'd6, 1'b0, 32'd1);

        // Reset in the middle of a launch with another command still queued.
        v = '{16'd2, 16'd2, 16'd2, 16'h0001, 16'h0002, 16'h0003, 4'd4, 0, 0, 1'b0, 32'd0};
        applyStimulus(v);
        v = '{16'd3, 16'd3, 16'd3, 16'h0004, 16'h0005, 16'h0006, 4'd8, 0, 0, 1'b0, 32'd0};
        applyStimulus(v);
        checkOutput("launch_before_reset", start_o, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_start", start_o, 0);
        checkOutput("async_reset_ready", cmd_ready_o, 1);
        checkOutput("async_reset_busy", busy_o, 0);
        checkOutput("async_reset_m", m_o, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | done_valid_o | start_o;
        end
        checkOutput("no_activity_after_reset", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
